// File: rtl/snoop_mem_responder.sv
// rtl/snoop_mem_responder.sv - memory-side responder for the MSI snooping bus
// Serves misses from a snoop flush or the local array, absorbs write-backs in IDLE.
module snoop_mem_responder #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 7,
  parameter int READ_LAT = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        bus_op,
  input  logic [ADDR_W-1:0] bus_tag,
  input  logic              snoop_hit,
  input  logic [DATA_W-1:0] snoop_data,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_tag,
  input  logic [DATA_W-1:0] wb_data,
  output logic              wb_ack,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              done,
  output logic              flushed
);

  typedef enum logic [2:0] {IDLE, SNOOP, WAIT, RESPOND, RELEASE} state_t;

  localparam int         DEPTH  = 2 ** ADDR_W;
  localparam logic [1:0] OP_INV = 2'b11;
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);

  state_t              state, next_state;
  logic [1:0]          op_q;
  logic [ADDR_W-1:0]   tag_q;
  logic [3:0]          cnt;
  logic [DATA_W-1:0]   data_q;
  logic                flush_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (!wb_req && bus_op != 2'b00) next_state = SNOOP;
      SNOOP:   next_state = (op_q == OP_INV || snoop_hit) ? RESPOND : WAIT;
      WAIT:    if (cnt == 4'd0) next_state = RESPOND;
      RESPOND: next_state = RELEASE;
      RELEASE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wb_ack     = (state == IDLE) && wb_req;
    busy       = (state != IDLE);
    done       = (state == RESPOND);
    resp_valid = (state == RESPOND) && (op_q != OP_INV);
    flushed    = (state == RESPOND) && flush_q;
  end

  // resp_data is a register so it holds between responses
  assign resp_data = data_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op_q    <= '0;
      tag_q   <= '0;
      cnt     <= '0;
      data_q  <= '0;
      flush_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (wb_req) begin
            mem[wb_tag] <= wb_data;
          end else if (bus_op != 2'b00) begin
            op_q  <= bus_op;
            tag_q <= bus_tag;
          end
        end
        SNOOP: begin
          if (op_q == OP_INV) begin
            data_q <= '0;
          end else if (snoop_hit) begin
            mem[tag_q] <= snoop_data;
            data_q     <= snoop_data;
            flush_q    <= 1'b1;
          end else begin
            cnt <= LAT_M1;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) data_q <= mem[tag_q];
          else             cnt    <= cnt - 4'd1;
        end
        RELEASE: flush_q <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/snoop_mem_responder.md
Name: snoop_mem_responder

Overview:
- Memory-side responder for the MSI snooping bus: the other end of the bus requests issued by the per-processor cache controllers.
- Accepts one bus transaction at a time: read miss, write miss or invalidate. Opens a one-cycle snoop window so any cache holding the line in M can flush it.
- Serves the line either from the flushing cache or from its own 32x7 array, with configurable array latency.
- Also absorbs eviction write-backs, replacing the simple RAM behind the bus.

Parameters:
- ADDR_W, 5, tag/address width; array depth is 2**ADDR_W.
- DATA_W, 7, data word width.
- READ_LAT, 2, array read latency in cycles; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- bus_op  in  2  bus request: 00 none, 01 read miss, 10 write miss, 11 invalidate. Held by the requester until done.
- bus_tag  in  ADDR_W  line address of bus_op.
- snoop_hit  in  1  OR of all caches: a cache holds bus_tag in M and is flushing it.
- snoop_data  in  DATA_W  flushed data, valid with snoop_hit.
- wb_req  in  1  eviction write-back strobe, single cycle.
- wb_tag  in  ADDR_W  write-back address.
- wb_data  in  DATA_W  write-back data.
- wb_ack  out  1  write-back accepted this cycle.
- busy  out  1  transaction in progress (state != IDLE).
- resp_valid  out  1  resp_data valid, one-cycle pulse.
- resp_data  out  DATA_W  line data for read/write miss.
- done  out  1  transaction complete, one-cycle pulse; requester drops bus_op on the following edge.
- flushed  out  1  pulses with done when data came from snoop_data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; latency counter 0; all array words 0.
  - Reset mid-transaction aborts it; no done pulse is produced.
- States: IDLE, SNOOP, WAIT, RESPOND, RELEASE.
- IDLE:
  - If wb_req=1: write wb_data to array[wb_tag] at the edge and assert wb_ack for that cycle (combinational from wb_req in IDLE). Any bus_op is deferred; the write-back has priority.
  - Else if bus_op!=00: latch op and tag, go to SNOOP.
- SNOOP (exactly 1 cycle):
  - Sample snoop_hit and snoop_data at the end of the cycle.
  - Invalidate: go to RESPOND with no data; snoop_hit is ignored.
  - Miss with hit: write snoop_data to array[tag], latch it as response data, set the flushed flag, go to RESPOND.
  - Miss without hit: load counter with READ_LAT-1, go to WAIT.
- WAIT:
  - Decrement the counter each cycle. When it is 0, latch array[tag] as response data and go to RESPOND.
  - Total WAIT time is READ_LAT cycles.
- RESPOND (1 cycle):
  - done=1.
  - resp_valid=1 for a read or write miss; resp_valid=0 for invalidate.
  - resp_data = latched data. For invalidate, resp_data=0.
  - flushed = latched flag.
  - Next state RELEASE.
- RELEASE (1 cycle):
  - bus_op is ignored, giving the requester time to drop it. wb_req is also ignored; write-backs are only accepted in IDLE.
  - Return to IDLE; clear the flushed flag.
- Latency (edge 0 = the edge IDLE captures bus_op):
  - Snoop-hit miss and invalidate: done visible in cycle 2.
  - Array miss: done visible in cycle 2+READ_LAT.
- wb_ack is low outside IDLE. The cache must hold wb_req/wb_tag/wb_data until it sees wb_ack.
- resp_data holds its last value between responses. It is reset to 0 and forced to 0 on invalidate.
- busy = (state!=IDLE).
- Tag and data paths are pure pass-through at the declared widths; no arithmetic.

Test Plan:
- Reset, then read miss at tag 5 (READ_LAT=2), no snoop hit -> resp_valid=1, resp_data=0, done=1 in cycle 4; busy high in cycles 1-5.
- wb_req tag 5 data 7'h2A in IDLE -> wb_ack=1 the same cycle. Then read miss tag 5 -> resp_data=7'h2A, flushed=0, done in cycle 4.
- Write miss tag 9 with snoop_hit=1, snoop_data=7'h55 during SNOOP -> done/resp_valid in cycle 2, resp_data=7'h55, flushed=1. A later read miss on tag 9 without hit returns 7'h55.
- Invalidate tag 3 -> done=1 in cycle 2 with resp_valid=0, resp_data=0; array[3] unchanged.
- wb_req and bus_op asserted in the same IDLE cycle -> write-back acked first, bus_op captured on the next edge. wb_req asserted during WAIT -> wb_ack=0 until IDLE.
- reset pulled low during WAIT -> all outputs 0 immediately, no done pulse. A following read of a previously written tag returns 0.
